// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the BTB/bimodal branch predictor
package bp_pkg;
  localparam logic [1:0] PHT_INIT = 2'b01;
  localparam logic [6:0] OP_BR = 7'h63;
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } bp_carry_t;
  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    return up ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/btb_array.sv
// btb_array: direct-mapped branch target buffer, combinational read, synchronous write
module btb_array import bp_pkg::*; #(
  parameter int IDX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc_i,
  output logic        hit_o,
  output logic [31:0] target_o,
  input  logic        we_i,
  input  logic [31:0] wr_pc_i,
  input  logic [31:0] wr_target_i
);
  localparam int N = 1 << IDX;
  localparam int TW = 30 - IDX;
  logic [N-1:0]    valid_q;
  logic [TW-1:0]   tag_q [N];
  logic [31:0]     tgt_q [N];
  logic [IDX-1:0]  ri, wi;
  assign ri = rd_pc_i[IDX+1:2];
  assign wi = wr_pc_i[IDX+1:2];
  assign hit_o = valid_q[ri] && (tag_q[ri] == rd_pc_i[31:IDX+2]);
  assign target_o = tgt_q[ri];
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (we_i) valid_q[wi] <= 1'b1;
  end
  // payload needs no reset: it is only observed through a set valid bit
  always_ff @(posedge clk) begin
    if (!rst && we_i) begin
      tag_q[wi] <= wr_pc_i[31:IDX+2];
      tgt_q[wi] <= wr_target_i;
    end
  end
endmodule

// File: rtl/btb_branch_predictor.sv
// btb_branch_predictor: BTB + bimodal PHT fetch predictor with prediction carry pipe to EX
module btb_branch_predictor import bp_pkg::*; #(
  parameter int PHT_IDX   = 8,
  parameter int BTB_IDX   = 5,
  parameter int RES_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loadReg,
  input  logic [31:0] pc_IF,
  input  logic [31:0] instr_IF,
  output logic        pred_branch_taken,
  output logic [31:0] pred_target,
  output logic        btb_hit,
  output logic        is_curr_branch,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        is_prev_branch,
  output logic        prev_branch_taken,
  output logic        prev_pred_branch_taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);
  localparam int PN = 1 << PHT_IDX;
  logic [1:0]  pht_q [PN];
  bp_carry_t   carry_q [RES_DEPTH];
  logic [31:0] btb_tgt;
  logic        upd;
  assign is_curr_branch = instr_IF[6:0] == OP_BR;
  btb_array #(.IDX(BTB_IDX)) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_pc_i     (pc_IF),
    .hit_o       (btb_hit),
    .target_o    (btb_tgt),
    .we_i        (upd & ex_taken),
    .wr_pc_i     (ex_pc),
    .wr_target_i (ex_target)
  );
  assign pred_branch_taken = btb_hit & is_curr_branch & pht_q[pc_IF[PHT_IDX+1:2]][1];
  assign pred_target = pred_branch_taken ? btb_tgt : pc_IF + 32'd4;
  assign is_prev_branch = ex_valid & ex_is_branch;
  assign prev_branch_taken = is_prev_branch & ex_taken;
  assign prev_pred_branch_taken = carry_q[RES_DEPTH-1].valid & carry_q[RES_DEPTH-1].taken;
  assign mispredict = is_prev_branch & ((prev_pred_branch_taken != ex_taken) |
                      (ex_taken & (carry_q[RES_DEPTH-1].target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  assign upd = loadReg & is_prev_branch;
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < PN; i++) pht_q[i] <= PHT_INIT;
    else if (upd) pht_q[ex_pc[PHT_IDX+1:2]] <= sat2(pht_q[ex_pc[PHT_IDX+1:2]], ex_taken);
  end
  // a resolved mispredict squashes every younger prediction still in flight
  always_ff @(posedge clk) begin
    if (rst || (loadReg && mispredict)) begin
      for (int i = 0; i < RES_DEPTH; i++) carry_q[i] <= '0;
    end else if (loadReg) begin
      carry_q[0] <= '{valid: is_curr_branch, taken: pred_branch_taken, target: pred_target};
      for (int i = 1; i < RES_DEPTH; i++) carry_q[i] <= carry_q[i-1];
    end
  end
endmodule

// File: tb/tb_btb_branch_predictor.sv
// tb_btb_branch_predictor: directed checks of lookup, training, mispredict flush, stall and aliasing
module tb_btb_branch_predictor;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst, loadReg;
  logic [31:0] pc_IF, instr_IF;
  logic        pred_branch_taken, btb_hit, is_curr_branch;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        is_prev_branch, prev_branch_taken, prev_pred_branch_taken, mispredict;
  logic [31:0] redirect_pc;
  int tests = 0;
  int fails = 0;

  btb_branch_predictor dut (
    .clk(clk), .rst(rst), .loadReg(loadReg), .pc_IF(pc_IF), .instr_IF(instr_IF),
    .pred_branch_taken(pred_branch_taken), .pred_target(pred_target), .btb_hit(btb_hit),
    .is_curr_branch(is_curr_branch), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .is_prev_branch(is_prev_branch), .prev_branch_taken(prev_branch_taken),
    .prev_pred_branch_taken(prev_pred_branch_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    pc_IF = pc;
    instr_IF = ins;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0;
    ex_pc = 32'h100; ex_target = 32'h0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = tk;
    ex_pc = pc; ex_target = tgt;
  endtask

  initial begin
    rst = 1'b1; loadReg = 1'b0;
    fetch(32'h60, BEQ); ex_idle();
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_hit", btb_hit, 0);
    chk("rst_pred", pred_branch_taken, 0);
    chk("rst_tgt", pred_target, 32'h64);
    chk("rst_isbr", is_curr_branch, 1);
    chk("rst_misp", mispredict, 0);
    chk("rst_redir", redirect_pc, 32'h104);
    chk("rst_carry", prev_pred_branch_taken, 0);
    chk("rst_isprev", is_prev_branch, 0);
    // first taken resolve of 0x60 while IF looks up the same index
    resolve(32'h60, 1'b1, 32'h40); loadReg = 1'b1; #1;
    chk("tr1_misp", mispredict, 1);
    chk("tr1_redir", redirect_pc, 32'h40);
    chk("tr1_isprev", is_prev_branch, 1);
    chk("tr1_prevtk", prev_branch_taken, 1);
    chk("rbw_hit", btb_hit, 0);
    chk("rbw_pred", pred_branch_taken, 0);
    tick();
    fetch(32'h200, NOP);
    tick();
    ex_idle(); fetch(32'h60, BEQ); #1;
    chk("trained_hit", btb_hit, 1);
    chk("trained_pred", pred_branch_taken, 1);
    chk("trained_tgt", pred_target, 32'h40);
    tick(); tick();
    fetch(32'h200, NOP); #1;
    chk("carry_taken", prev_pred_branch_taken, 1);
    chk("carry_nobr_misp", mispredict, 0);
    fetch(32'he0, BEQ); #1;
    chk("alias_hit", btb_hit, 0);
    chk("alias_pred", pred_branch_taken, 0);
    chk("alias_tgt", pred_target, 32'he4);
    // stall with a mispredicting branch sitting in EX
    fetch(32'h200, NOP); loadReg = 1'b0; resolve(32'h60, 1'b0, 32'h40);
    repeat (5) tick();
    fetch(32'h60, BEQ); #1;
    chk("stall_carry", prev_pred_branch_taken, 1);
    chk("stall_misp", mispredict, 1);
    chk("stall_redir", redirect_pc, 32'h64);
    chk("stall_pred", pred_branch_taken, 1);
    chk("stall_tgt", pred_target, 32'h40);
    loadReg = 1'b1;
    tick();
    ex_idle(); #1;
    chk("flush_carry", prev_pred_branch_taken, 0);
    chk("nt_keep_hit", btb_hit, 1);
    chk("pht_10_pred", pred_branch_taken, 1);
    fetch(32'h200, NOP); resolve(32'h60, 1'b0, 32'h0); #1;
    chk("nt_nomisp", mispredict, 0);
    tick();
    ex_idle(); fetch(32'h60, BEQ); #1;
    chk("pht_01_pred", pred_branch_taken, 0);
    chk("pht_01_tgt", pred_target, 32'h64);
    fetch(32'h200, NOP); resolve(32'h60, 1'b0, 32'h0);
    repeat (3) tick();
    resolve(32'h60, 1'b1, 32'h40);
    tick();
    ex_idle(); fetch(32'h60, BEQ); #1;
    chk("sat0_pred", pred_branch_taken, 0);
    // 32-bit wrap and non-branch EX
    loadReg = 1'b0; fetch(32'hffff_fffc, NOP);
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_pc = 32'hffff_fffc; #1;
    chk("wrap_tgt", pred_target, 32'h0);
    chk("wrap_isbr", is_curr_branch, 0);
    chk("wrap_redir", redirect_pc, 32'h0);
    chk("nobr_isprev", is_prev_branch, 0);
    ex_taken = 1'b1; ex_target = 32'h1234; #1;
    chk("nobr_prevtk", prev_branch_taken, 0);
    chk("nobr_misp", mispredict, 0);
    chk("redir_taken", redirect_pc, 32'h1234);
    // reset overrides a concurrent update
    loadReg = 1'b1; resolve(32'h60, 1'b1, 32'h40); fetch(32'h60, BEQ); rst = 1'b1;
    tick();
    rst = 1'b0; ex_idle(); #1;
    chk("mrst_hit", btb_hit, 0);
    chk("mrst_pred", pred_branch_taken, 0);
    chk("mrst_carry", prev_pred_branch_taken, 0);
    fetch(32'h200, NOP); resolve(32'h60, 1'b1, 32'h40);
    tick();
    ex_idle(); fetch(32'h60, BEQ); #1;
    chk("mrst_retrain", pred_branch_taken, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
